axil_arbiter: RTL and testbench

AXIL_ARBITER -- requirements
Module: axil_arbiter

---
 rtl/arb_pkg.sv | 23 ++
 rtl/axil_arbiter.sv | 175 +++++++++++++++++
 tb/tb_axil_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Brief    : Shared types for the AXI-Lite IFU/LSU arbiter: FSM state
//             encodings and master identifiers.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_IFU_R = 2'd1,
      ST_LSU_R = 2'd2,
      ST_LSU_W = 2'd3
   } arb_state_t;

   typedef enum logic {
      MST_IFU = 1'b0,
      MST_LSU = 1'b1
   } master_t;

endpackage
`default_nettype wire

// File: rtl/axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axil_arbiter
//  Brief    : Two-master (IFU read-only, LSU read/write) to one-slave
//             AXI-Lite arbiter. One transaction at a time, round-robin
//             between IFU and LSU, LSU reads ahead of LSU writes.
//  Revision : 1.0 - initial release
// ============================================================================
module axil_arbiter
   import arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   // IFU read
   input  logic [31:0] ifu_araddr,
   input  logic        ifu_arvalid,
   output logic        ifu_arready,
   output logic [31:0] ifu_rdata,
   output logic [1:0]  ifu_rresp,
   output logic        ifu_rvalid,
   input  logic        ifu_rready,
   // LSU read
   input  logic [31:0] lsu_araddr,
   input  logic        lsu_arvalid,
   output logic        lsu_arready,
   output logic [31:0] lsu_rdata,
   output logic [1:0]  lsu_rresp,
   output logic        lsu_rvalid,
   input  logic        lsu_rready,
   // LSU write
   input  logic [31:0] lsu_awaddr,
   input  logic        lsu_awvalid,
   output logic        lsu_awready,
   input  logic [31:0] lsu_wdata,
   input  logic [1:0]  lsu_wstrb,
   input  logic        lsu_wvalid,
   output logic        lsu_wready,
   output logic [1:0]  lsu_bresp,
   output logic        lsu_bvalid,
   input  logic        lsu_bready,
   // Downstream read
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   // Downstream write
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [1:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   // Debug
   output logic        grant_lsu
);

   arb_state_t r_state;
   arb_state_t w_next;
   master_t    r_last;
   logic       r_grant_lsu;

   logic       w_ifu_req;
   logic       w_lsu_rd;
   logic       w_lsu_wr;
   logic       w_lsu_req;

   assign w_ifu_req = ifu_arvalid;
   assign w_lsu_rd  = lsu_arvalid;
   assign w_lsu_wr  = lsu_awvalid && lsu_wvalid;
   assign w_lsu_req = w_lsu_rd || w_lsu_wr;
   assign grant_lsu = r_grant_lsu;

   // Next-state: arbitrate in IDLE, hold a grant until its response handshake.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            // On a tie the master not granted last time wins.
            if (w_lsu_req && (!w_ifu_req || r_last == MST_IFU))
               w_next = w_lsu_rd ? ST_LSU_R : ST_LSU_W;
            else if (w_ifu_req)
               w_next = ST_IFU_R;
         end
         ST_IFU_R: if (rvalid && ifu_rready) w_next = ST_IDLE;
         ST_LSU_R: if (rvalid && lsu_rready) w_next = ST_IDLE;
         ST_LSU_W: if (bvalid && lsu_bready) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // State, round-robin history and grant flag; history/flag move only on a new grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_last      <= MST_IFU;
         r_grant_lsu <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_next != ST_IDLE) begin
            r_last      <= (w_next == ST_IFU_R) ? MST_IFU : MST_LSU;
            r_grant_lsu <= (w_next != ST_IFU_R);
         end
      end
   end

   // Channel mux: only the granted master is connected; reset silences everything
   // at once so a response arriving during reset never reaches a master.
   always_comb begin
      ifu_arready = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = '0;
      ifu_rvalid  = 1'b0;
      lsu_arready = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = '0;
      lsu_rvalid  = 1'b0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bresp   = '0;
      lsu_bvalid  = 1'b0;
      araddr      = '0;
      arvalid     = 1'b0;
      rready      = 1'b0;
      awaddr      = '0;
      awvalid     = 1'b0;
      wdata       = '0;
      wstrb       = '0;
      wvalid      = 1'b0;
      bready      = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IFU_R: begin
               araddr      = ifu_araddr;
               arvalid     = ifu_arvalid;
               ifu_arready = arready;
               ifu_rdata   = rdata;
               ifu_rresp   = rresp;
               ifu_rvalid  = rvalid;
               rready      = ifu_rready;
            end
            ST_LSU_R: begin
               araddr      = lsu_araddr;
               arvalid     = lsu_arvalid;
               lsu_arready = arready;
               lsu_rdata   = rdata;
               lsu_rresp   = rresp;
               lsu_rvalid  = rvalid;
               rready      = lsu_rready;
            end
            ST_LSU_W: begin
               awaddr      = lsu_awaddr;
               awvalid     = lsu_awvalid;
               lsu_awready = awready;
               wdata       = lsu_wdata;
               wstrb       = lsu_wstrb;
               wvalid      = lsu_wvalid;
               lsu_wready  = wready;
               lsu_bresp   = bresp;
               lsu_bvalid  = bvalid;
               bready      = lsu_bready;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_arbiter
//  Brief    : Self-checking bench for axil_arbiter. Requests push their
//             expected transaction into a scoreboard; a downstream slave
//             model pops and checks each grant as it appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ifu_araddr = '0;
   logic        ifu_arvalid = 1'b0, ifu_rready = 1'b1;
   logic        ifu_arready, ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic [31:0] lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0;
   logic        lsu_arvalid = 1'b0, lsu_rready = 1'b1, lsu_awvalid = 1'b0;
   logic        lsu_wvalid = 1'b0, lsu_bready = 1'b1;
   logic [1:0]  lsu_wstrb = '0;
   logic        lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
   logic [31:0] lsu_rdata;
   logic [1:0]  lsu_rresp, lsu_bresp;
   logic [31:0] araddr, awaddr, wdata;
   logic        arvalid, rready, awvalid, wvalid, bready;
   logic [1:0]  wstrb;
   logic        arready = 1'b1, awready = 1'b1, wready = 1'b1;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0, bresp = '0;
   logic        rvalid = 1'b0, bvalid = 1'b0;
   logic        grant_lsu;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          lsu;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  strb;
      logic [1:0]  resp;
   } txn_t;

   txn_t sb[$];

   always #5 clk = ~clk;

   axil_arbiter dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
      .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .grant_lsu(grant_lsu)
   );

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic req_ifu(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      txn_t t;
      ifu_araddr = a; ifu_arvalid = 1'b1;
      t.lsu = 1'b0; t.wr = 1'b0; t.addr = a; t.data = d; t.strb = '0; t.resp = r;
      sb.push_back(t);
   endtask

   task automatic req_lsu_rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      txn_t t;
      lsu_araddr = a; lsu_arvalid = 1'b1;
      t.lsu = 1'b1; t.wr = 1'b0; t.addr = a; t.data = d; t.strb = '0; t.resp = r;
      sb.push_back(t);
   endtask

   task automatic req_lsu_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                             input logic [1:0] r);
      txn_t t;
      lsu_awaddr = a; lsu_awvalid = 1'b1; lsu_wdata = d; lsu_wstrb = s; lsu_wvalid = 1'b1;
      t.lsu = 1'b1; t.wr = 1'b1; t.addr = a; t.data = d; t.strb = s; t.resp = r;
      sb.push_back(t);
   endtask

   // Downstream slave: wait for the next grant, check it against the scoreboard head,
   // return the response, then check the one-cycle IDLE bubble.
   task automatic serve();
      txn_t t;
      int   n = 0;
      bit   seen = 1'b0;
      while (!seen && n < 10) begin
         @(negedge clk); #1;
         n++;
         seen = arvalid || awvalid;
      end
      total++;
      if (!seen || sb.size() == 0) begin
         bad++;
         $display("FAIL serve_grant: seen=%0b sb_size=%0d required seen=1 with pending txn",
                  seen, sb.size());
         return;
      end
      t = sb.pop_front();
      total++;
      if (n !== 1) begin
         bad++;
         $display("FAIL latency: got %0d cycles required 1", n);
      end
      total++;
      if (grant_lsu !== t.lsu || awvalid !== t.wr) begin
         bad++;
         $display("FAIL grant_owner: grant_lsu=%0b awvalid=%0b required %0b/%0b",
                  grant_lsu, awvalid, t.lsu, t.wr);
      end
      if (!t.wr) begin
         total++;
         if (araddr !== t.addr || ifu_arready !== !t.lsu || lsu_arready !== t.lsu
             || lsu_awready !== 1'b0) begin
            bad++;
            $display("FAIL rd_addr: araddr=%h ifu_rdy=%0b lsu_rdy=%0b required %h %0b %0b",
                     araddr, ifu_arready, lsu_arready, t.addr, !t.lsu, t.lsu);
         end
         @(negedge clk);
         rvalid = 1'b1; rdata = t.data; rresp = t.resp;
         if (t.lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
         #1;
         total++;
         if (t.lsu ? (lsu_rvalid !== 1'b1 || lsu_rdata !== t.data || lsu_rresp !== t.resp
                      || ifu_rvalid !== 1'b0)
                   : (ifu_rvalid !== 1'b1 || ifu_rdata !== t.data || ifu_rresp !== t.resp
                      || lsu_rvalid !== 1'b0)) begin
            bad++;
            $display("FAIL rd_data: ifu v=%0b d=%h r=%0d lsu v=%0b d=%h r=%0d required lsu=%0b d=%h r=%0d",
                     ifu_rvalid, ifu_rdata, ifu_rresp, lsu_rvalid, lsu_rdata, lsu_rresp,
                     t.lsu, t.data, t.resp);
         end
      end else begin
         total++;
         if (awaddr !== t.addr || wdata !== t.data || wstrb !== t.strb || wvalid !== 1'b1
             || lsu_awready !== 1'b1 || lsu_wready !== 1'b1 || ifu_arready !== 1'b0) begin
            bad++;
            $display("FAIL wr_fwd: awaddr=%h wdata=%h wstrb=%0d wvalid=%0b required %h %h %0d 1",
                     awaddr, wdata, wstrb, wvalid, t.addr, t.data, t.strb);
         end
         @(negedge clk);
         bvalid = 1'b1; bresp = t.resp;
         lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
         #1;
         total++;
         if (lsu_bvalid !== 1'b1 || lsu_bresp !== t.resp || ifu_rvalid !== 1'b0
             || lsu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL wr_resp: lsu_bvalid=%0b lsu_bresp=%0d ifu_rvalid=%0b required 1 %0d 0",
                     lsu_bvalid, lsu_bresp, ifu_rvalid, t.resp);
         end
      end
      @(negedge clk);
      rvalid = 1'b0; bvalid = 1'b0; rdata = '0; rresp = '0; bresp = '0;
      #1;
      total++;
      if (arvalid !== 1'b0 || awvalid !== 1'b0 || ifu_arready !== 1'b0 || lsu_arready !== 1'b0) begin
         bad++;
         $display("FAIL bubble: arvalid=%0b awvalid=%0b ifu_rdy=%0b lsu_rdy=%0b required all 0",
                  arvalid, awvalid, ifu_arready, lsu_arready);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++;
      if (grant_lsu !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0
          || rready !== 1'b0 || bready !== 1'b0 || araddr !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: grant_lsu=%0b arvalid=%0b awvalid=%0b rready=%0b required all 0",
                  grant_lsu, arvalid, awvalid, rready);
      end
   endtask

   task automatic test_ifu_read();
      @(negedge clk);
      req_ifu(32'h8000_0000, 32'h1234_5678, 2'd0);
      #1;
      total++;
      if (arvalid !== 1'b0 || ifu_arready !== 1'b0) begin
         bad++;
         $display("FAIL idle_quiet: arvalid=%0b ifu_arready=%0b required 0 0", arvalid, ifu_arready);
      end
      serve();
   endtask

   task automatic test_round_robin();
      do_reset();
      req_lsu_rd(32'h0000_1000, 32'hAAAA_0001, 2'd2);
      req_ifu(32'h8000_0004, 32'hBBBB_0002, 2'd0);
      serve();
      serve();
      @(negedge clk);
      req_lsu_rd(32'h0000_2000, 32'hCCCC_0003, 2'd0);
      req_ifu(32'h8000_0008, 32'hDDDD_0004, 2'd3);
      serve();
      serve();
   endtask

   task automatic test_write();
      @(negedge clk);
      req_lsu_wr(32'ha000_03f8, 32'h0000_0041, 2'd0, 2'd0);
      serve();
      @(negedge clk);
      req_lsu_wr(32'h0000_0010, 32'hDEAD_BEEF, 2'd2, 2'd2);
      serve();
   endtask

   task automatic test_rd_over_wr();
      @(negedge clk);
      req_lsu_rd(32'h0000_3000, 32'h5555_AAAA, 2'd1);
      req_lsu_wr(32'h0000_4000, 32'h0F0F_0F0F, 2'd1, 2'd3);
      serve();
      serve();
   endtask

   task automatic test_hold_grant();
      @(negedge clk);
      req_ifu(32'h8000_0100, 32'h7777_8888, 2'd0);
      @(negedge clk);
      ifu_arvalid = 1'b0;
      void'(sb.pop_front());
      req_lsu_rd(32'h0000_5000, 32'h9999_0000, 2'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         total++;
         if (lsu_arready !== 1'b0 || grant_lsu !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b1) begin
            bad++;
            $display("FAIL hold_grant: cyc=%0d lsu_arready=%0b grant_lsu=%0b arvalid=%0b rready=%0b required 0 0 0 1",
                     i, lsu_arready, grant_lsu, arvalid, rready);
         end
      end
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'h7777_8888;
      #1;
      total++;
      if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h7777_8888 || lsu_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL hold_resp: ifu_rvalid=%0b ifu_rdata=%h lsu_rvalid=%0b required 1 77778888 0",
                  ifu_rvalid, ifu_rdata, lsu_rvalid);
      end
      @(negedge clk);
      rvalid = 1'b0; rdata = '0;
      serve();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_lsu_wr(32'h0000_6000, 32'h1111_2222, 2'd3, 2'd0);
      void'(sb.pop_front());
      @(negedge clk); #1;
      total++;
      if (grant_lsu !== 1'b1 || awvalid !== 1'b1) begin
         bad++;
         $display("FAIL mid_grant: grant_lsu=%0b awvalid=%0b required 1 1", grant_lsu, awvalid);
      end
      @(negedge clk);
      lsu_bready = 1'b0; bvalid = 1'b1; bresp = 2'd1; rst = 1'b1;
      lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
      #1;
      total++;
      if (lsu_bvalid !== 1'b0) begin
         bad++;
         $display("FAIL rst_bvalid: lsu_bvalid=%0b required 0", lsu_bvalid);
      end
      @(negedge clk); #1;
      total++;
      if (lsu_bvalid !== 1'b0 || grant_lsu !== 1'b0 || awvalid !== 1'b0 || bready !== 1'b0) begin
         bad++;
         $display("FAIL rst_abort: lsu_bvalid=%0b grant_lsu=%0b awvalid=%0b bready=%0b required 0 0 0 0",
                  lsu_bvalid, grant_lsu, awvalid, bready);
      end
      rst = 1'b0; lsu_bready = 1'b1;
      @(negedge clk); #1;
      total++;
      if (lsu_bvalid !== 1'b0 || awvalid !== 1'b0) begin
         bad++;
         $display("FAIL post_rst_idle: lsu_bvalid=%0b awvalid=%0b required 0 0", lsu_bvalid, awvalid);
      end
      bvalid = 1'b0; bresp = '0;
   endtask

   initial begin
      test_reset();
      test_ifu_read();
      test_round_robin();
      test_write();
      test_rd_over_wr();
      test_hold_grant();
      test_reset_mid();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: left=%0d required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
